// File: rtl/rec_addr_seq_if.sv
// Recorder address-sequencer bus: mode/tick from the controller, memory strobes and status back.
// master = controller side, slave = rec_addr_seq.
interface rec_addr_seq_if #(
  parameter int unsigned ADDR_W = 16
);
  logic [2:0]        state;
  logic              sample_tick;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic              mem_re;
  logic              rd_valid;
  logic              finish;
  logic              full;
  logic [ADDR_W:0]   rec_len;

  modport master (
    output state, sample_tick,
    input  mem_addr, mem_we, mem_re, rd_valid, finish, full, rec_len
  );

  modport slave (
    input  state, sample_tick,
    output mem_addr, mem_we, mem_re, rd_valid, finish, full, rec_len
  );
endinterface

// File: rtl/rec_addr_seq.sv
// Sample-memory address sequencer for a voice recorder: record, play, fast forward and rewind.
// Optional macro PLAY_LOOP_EN: normal playback wraps to the first sample instead of finishing.
module rec_addr_seq #(
  parameter int unsigned ADDR_W = 16
) (
  input logic            clk,
  input logic            rst_n,
  rec_addr_seq_if.slave  io_bus
);

  typedef enum logic [2:0] {
    ModeInit      = 3'b000,
    ModeRec       = 3'b001,
    ModeRecPause  = 3'b010,
    ModeRecFinish = 3'b011,
    ModePlay      = 3'b100,
    ModePlayPause = 3'b101,
    ModeFwd       = 3'b110,
    ModeBack      = 3'b111
  } mode_e;

  localparam logic [ADDR_W:0] PtrOne = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] PtrTwo = (ADDR_W+1)'(2);
  localparam logic [ADDR_W:0] Depth  = {1'b1, {ADDR_W{1'b0}}};

  logic [ADDR_W:0]   r_wr_ptr, w_wr_d;
  logic [ADDR_W:0]   r_rd_ptr, w_rd_d;
  logic [ADDR_W-1:0] r_mem_addr, w_addr_d;
  logic              r_mem_we, w_we_d;
  logic              r_mem_re, w_re_d;
  logic              r_rd_valid;
  logic              r_finish, w_fin_d;
  logic              r_full, w_full_d;

  mode_e             w_mode;
  logic [ADDR_W:0]   w_wr_inc;
  logic [ADDR_W:0]   w_rd_fwd;
  logic [ADDR_W:0]   w_rd_dec;
`ifdef PLAY_LOOP_EN
  logic [ADDR_W:0]   w_loop_base;
  logic [ADDR_W:0]   w_loop_inc;
`else
  logic [ADDR_W:0]   w_rd_inc;
`endif

  assign w_mode   = mode_e'(io_bus.state);
  assign w_wr_inc = r_wr_ptr + PtrOne;
  assign w_rd_fwd = r_rd_ptr + PtrTwo;
  assign w_rd_dec = r_rd_ptr - PtrOne;
`ifdef PLAY_LOOP_EN
  // A pointer left at the end by fast forward restarts from the first sample.
  assign w_loop_base = (r_rd_ptr >= r_wr_ptr) ? '0 : r_rd_ptr;
  assign w_loop_inc  = w_loop_base + PtrOne;
`else
  assign w_rd_inc = r_rd_ptr + PtrOne;
`endif

  always_comb begin
    w_wr_d   = r_wr_ptr;
    w_rd_d   = r_rd_ptr;
    w_addr_d = r_mem_addr;
    w_we_d   = 1'b0;
    w_re_d   = 1'b0;
    w_fin_d  = r_finish;
    w_full_d = r_full;
    case (w_mode)
      ModeInit: begin
        w_wr_d   = '0;
        w_rd_d   = '0;
        w_fin_d  = 1'b0;
        w_full_d = 1'b0;
      end
      ModeRec: begin
        if (io_bus.sample_tick && !r_full) begin
          w_addr_d = r_wr_ptr[ADDR_W-1:0];
          w_we_d   = 1'b1;
          w_wr_d   = w_wr_inc;
          w_full_d = (w_wr_inc == Depth);
        end
      end
      ModeRecFinish: begin
        w_rd_d  = '0;
        w_fin_d = 1'b0;
      end
      ModePlay: begin
        if (io_bus.sample_tick) begin
`ifdef PLAY_LOOP_EN
          if (r_wr_ptr != '0) begin
            w_addr_d = w_loop_base[ADDR_W-1:0];
            w_re_d   = 1'b1;
            w_rd_d   = (w_loop_inc == r_wr_ptr) ? '0 : w_loop_inc;
          end
`else
          if (r_rd_ptr < r_wr_ptr) begin
            w_addr_d = r_rd_ptr[ADDR_W-1:0];
            w_re_d   = 1'b1;
            w_rd_d   = w_rd_inc;
            w_fin_d  = r_finish | (w_rd_inc == r_wr_ptr);
          end else begin
            w_fin_d = 1'b1;
          end
`endif
        end
      end
      ModeFwd: begin
        if (io_bus.sample_tick) begin
          if (r_rd_ptr < r_wr_ptr) begin
            w_addr_d = r_rd_ptr[ADDR_W-1:0];
            w_re_d   = 1'b1;
            if (w_rd_fwd >= r_wr_ptr) begin
              w_rd_d  = r_wr_ptr;
              w_fin_d = 1'b1;
            end else begin
              w_rd_d = w_rd_fwd;
            end
          end else begin
            w_fin_d = 1'b1;
          end
        end
      end
      ModeBack: begin
        if (io_bus.sample_tick) begin
          if (r_rd_ptr != '0) begin
            w_addr_d = w_rd_dec[ADDR_W-1:0];
            w_re_d   = 1'b1;
            if (r_rd_ptr <= PtrTwo) begin
              w_rd_d  = '0;
              w_fin_d = 1'b1;
            end else begin
              w_rd_d = r_rd_ptr - PtrTwo;
            end
          end else begin
            w_fin_d = 1'b1;
          end
        end
      end
      default: ;  // pause modes and unknown codes hold everything
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_mem_addr <= '0;
      r_mem_we   <= 1'b0;
      r_mem_re   <= 1'b0;
      r_rd_valid <= 1'b0;
      r_finish   <= 1'b0;
      r_full     <= 1'b0;
    end else begin
      r_wr_ptr   <= w_wr_d;
      r_rd_ptr   <= w_rd_d;
      r_mem_addr <= w_addr_d;
      r_mem_we   <= w_we_d;
      r_mem_re   <= w_re_d;
      r_rd_valid <= r_mem_re;
      r_finish   <= w_fin_d;
      r_full     <= w_full_d;
    end
  end

  assign io_bus.mem_addr = r_mem_addr;
  assign io_bus.mem_we   = r_mem_we;
  assign io_bus.mem_re   = r_mem_re;
  assign io_bus.rd_valid = r_rd_valid;
  assign io_bus.finish   = r_finish;
  assign io_bus.full     = r_full;
  assign io_bus.rec_len  = r_wr_ptr;

endmodule

// File: tb/tb_rec_addr_seq.sv
// Self-checking bench for rec_addr_seq: directed scenarios plus random mode/tick traffic
// compared cycle by cycle against an integer model of the recorder pointers.
module tb_rec_addr_seq;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int VW    = 5 + AW + AW + 1;
`ifdef PLAY_LOOP_EN
  localparam bit LOOP = 1'b1;
`else
  localparam bit LOOP = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_fail;

  rec_addr_seq_if #(.ADDR_W(AW)) bus ();

  rec_addr_seq #(.ADDR_W(AW)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: pointers as plain integers, outputs as seen after the latest edge.
  int m_wr, m_rd, m_addr;
  bit m_we, m_re, m_rv, m_fin, m_full;

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_addr = 0;
    m_we = 0; m_re = 0; m_rv = 0; m_fin = 0; m_full = 0;
  endtask

  task automatic model_edge(input logic [2:0] st, input logic tk);
    m_rv = m_re;
    m_we = 0;
    m_re = 0;
    case (st)
      3'd0: begin m_wr = 0; m_rd = 0; m_fin = 0; m_full = 0; end
      3'd1: if (tk && !m_full) begin
        m_addr = m_wr; m_we = 1; m_wr++;
        m_full = (m_wr == DEPTH);
      end
      3'd3: begin m_rd = 0; m_fin = 0; end
      3'd4: if (tk) begin
        if (LOOP) begin
          if (m_wr > 0) begin
            int p;
            p = (m_rd >= m_wr) ? 0 : m_rd;
            m_addr = p; m_re = 1; m_rd = (p + 1) % m_wr;
          end
        end else if (m_rd < m_wr) begin
          m_addr = m_rd; m_re = 1; m_rd++;
          if (m_rd == m_wr) m_fin = 1;
        end else m_fin = 1;
      end
      3'd6: if (tk) begin
        if (m_rd < m_wr) begin
          m_addr = m_rd; m_re = 1;
          m_rd = (m_rd + 2 < m_wr) ? m_rd + 2 : m_wr;
          if (m_rd == m_wr) m_fin = 1;
        end else m_fin = 1;
      end
      3'd7: if (tk) begin
        if (m_rd > 0) begin
          m_addr = m_rd - 1; m_re = 1;
          m_rd = (m_rd - 2 > 0) ? m_rd - 2 : 0;
          if (m_rd == 0) m_fin = 1;
        end else m_fin = 1;
      end
      default: ;
    endcase
  endtask

  function automatic logic [VW-1:0] dut_vec();
    return {bus.mem_we, bus.mem_re, bus.rd_valid, bus.finish, bus.full, bus.mem_addr, bus.rec_len};
  endfunction

  function automatic logic [VW-1:0] mdl_vec();
    logic [AW-1:0] a;
    logic [AW:0]   l;
    a = m_addr[AW-1:0];
    l = m_wr[AW:0];
    return {m_we, m_re, m_rv, m_fin, m_full, a, l};
  endfunction

  // Apply inputs for one clock, advance the model, then settle 1ns past the edge.
  task automatic cyc(input logic [2:0] st, input logic tk);
    bus.state       = st;
    bus.sample_tick = tk;
    @(posedge clk);
    model_edge(st, tk);
    #1;
  endtask

  task automatic test_reset();
    logic [VW-1:0] zero;
    zero = '0;
    rst_n = 1'b1;
    bus.state = 3'd1;
    bus.sample_tick = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    model_reset();
    n_chk++;
    if (dut_vec() !== zero) begin
      n_fail++; $display("FAIL reset_async: got %h want %h", dut_vec(), zero);
    end
    repeat (2) @(posedge clk);
    #1;
    n_chk++;
    if (dut_vec() !== zero) begin
      n_fail++; $display("FAIL reset_hold: got %h want %h", dut_vec(), zero);
    end
    bus.sample_tick = 1'b0;
    #4 rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc(3'd1, 1'b0);
      n_chk++;
      if ({bus.mem_we, bus.mem_re} !== 2'b00) begin
        n_fail++; $display("FAIL reset_no_strobe: got %b want 00", {bus.mem_we, bus.mem_re});
      end
    end
  endtask

  task automatic test_record();
    cyc(3'd0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(3'd1, 1'b1);
      n_chk++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL rec_vec %0d: got %h want %h", i, dut_vec(), mdl_vec());
      end
      n_chk++;
      if (bus.mem_we !== 1'b1 || bus.mem_addr !== i[AW-1:0]) begin
        n_fail++; $display("FAIL rec_write %0d: we=%b addr=%0d want we=1 addr=%0d",
                           i, bus.mem_we, bus.mem_addr, i);
      end
      cyc(3'd1, 1'b0);
      n_chk++;
      if (bus.mem_we !== 1'b0) begin
        n_fail++; $display("FAIL rec_we_pulse %0d: got %b want 0", i, bus.mem_we);
      end
    end
    n_chk++;
    if (bus.rec_len !== 5'd5 || bus.full !== 1'b0) begin
      n_fail++; $display("FAIL rec_len5: rec_len=%0d full=%b want 5 0", bus.rec_len, bus.full);
    end
  endtask

  task automatic test_play();
    cyc(3'd3, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(3'd4, 1'b1);
      n_chk++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL play_vec %0d: got %h want %h", i, dut_vec(), mdl_vec());
      end
      n_chk++;
      if (bus.mem_re !== 1'b1 || bus.mem_addr !== i[AW-1:0] ||
          bus.finish !== (!LOOP && i == 4)) begin
        n_fail++; $display("FAIL play_read %0d: re=%b addr=%0d fin=%b want 1 %0d %b",
                           i, bus.mem_re, bus.mem_addr, bus.finish, i, (!LOOP && i == 4));
      end
      cyc(3'd4, 1'b0);
      n_chk++;
      if (bus.rd_valid !== 1'b1 || bus.mem_re !== 1'b0) begin
        n_fail++; $display("FAIL play_rd_valid %0d: rv=%b re=%b want 1 0", i, bus.rd_valid,
                           bus.mem_re);
      end
    end
  endtask

  task automatic test_fwd_back();
    int exp_f[4];
    int exp_b[5];
    exp_f = '{2, 4, 6, 8};
    exp_b = '{9, 7, 5, 3, 1};
    cyc(3'd0, 1'b0);
    repeat (10) begin cyc(3'd1, 1'b1); cyc(3'd1, 1'b0); end
    cyc(3'd3, 1'b0);
    repeat (2) begin cyc(3'd4, 1'b1); cyc(3'd4, 1'b0); end
    for (int i = 0; i < 4; i++) begin
      cyc(3'd6, 1'b1);
      n_chk++;
      if (dut_vec() !== mdl_vec() || bus.mem_re !== 1'b1 || bus.mem_addr !== exp_f[i][AW-1:0])
      begin
        n_fail++; $display("FAIL fwd_read %0d: got %h addr=%0d want %h addr=%0d",
                           i, dut_vec(), bus.mem_addr, mdl_vec(), exp_f[i]);
      end
      cyc(3'd6, 1'b0);
    end
    n_chk++;
    if (bus.finish !== 1'b1) begin
      n_fail++; $display("FAIL fwd_finish: got %b want 1", bus.finish);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(3'd7, 1'b1);
      n_chk++;
      if (dut_vec() !== mdl_vec() || bus.mem_re !== 1'b1 || bus.mem_addr !== exp_b[i][AW-1:0])
      begin
        n_fail++; $display("FAIL back_read %0d: got %h addr=%0d want %h addr=%0d",
                           i, dut_vec(), bus.mem_addr, mdl_vec(), exp_b[i]);
      end
      cyc(3'd7, 1'b0);
    end
    cyc(3'd7, 1'b1);
    n_chk++;
    if (bus.mem_re !== 1'b0 || bus.finish !== 1'b1) begin
      n_fail++; $display("FAIL back_at_start: re=%b fin=%b want 0 1", bus.mem_re, bus.finish);
    end
  endtask

  task automatic test_full();
    int nw;
    nw = 0;
    cyc(3'd0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      cyc(3'd1, 1'b1);
      n_chk++;
      if (dut_vec() !== mdl_vec()) begin
        n_fail++; $display("FAIL full_vec %0d: got %h want %h", i, dut_vec(), mdl_vec());
      end
      if (bus.mem_we === 1'b1) begin
        n_chk++;
        if (bus.mem_addr !== nw[AW-1:0]) begin
          n_fail++; $display("FAIL full_addr %0d: got %0d want %0d", i, bus.mem_addr, nw);
        end
        nw++;
      end
    end
    n_chk++;
    if (nw != DEPTH || bus.full !== 1'b1 || bus.rec_len !== 5'd16) begin
      n_fail++; $display("FAIL full_end: writes=%0d full=%b len=%0d want 16 1 16",
                         nw, bus.full, bus.rec_len);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [VW-1:0] zero;
    zero = '0;
    cyc(3'd0, 1'b0);
    repeat (4) cyc(3'd1, 1'b1);
    cyc(3'd3, 1'b0);
    cyc(3'd4, 1'b1);
    cyc(3'd4, 1'b1);
    n_chk++;
    if (dut_vec() !== mdl_vec() || bus.mem_re !== 1'b1) begin
      n_fail++; $display("FAIL midread_pre: got %h want %h", dut_vec(), mdl_vec());
    end
    #1 rst_n = 1'b0;
    #1;
    model_reset();
    n_chk++;
    if (dut_vec() !== zero) begin
      n_fail++; $display("FAIL midread_reset: got %h want %h", dut_vec(), zero);
    end
    #2 rst_n = 1'b1;
    cyc(3'd0, 1'b0);
  endtask

  task automatic test_loop();
    cyc(3'd0, 1'b0);
    repeat (3) begin cyc(3'd1, 1'b1); cyc(3'd1, 1'b0); end
    cyc(3'd3, 1'b0);
    for (int i = 0; i < 7; i++) begin
      bit exp_re;
      int exp_a;
      bit exp_f;
      exp_re = LOOP || i < 3;
      exp_a  = i % 3;
      exp_f  = !LOOP && i >= 2;
      cyc(3'd4, 1'b1);
      n_chk++;
      if (dut_vec() !== mdl_vec() || bus.mem_re !== exp_re || bus.finish !== exp_f ||
          (exp_re && bus.mem_addr !== exp_a[AW-1:0])) begin
        n_fail++; $display("FAIL loop_read %0d: re=%b addr=%0d fin=%b want %b %0d %b",
                           i, bus.mem_re, bus.mem_addr, bus.finish, exp_re, exp_a, exp_f);
      end
      cyc(3'd4, 1'b0);
    end
  endtask

  task automatic test_random();
    logic [2:0] st;
    logic [2:0] map[16];
    map = '{3'd0, 3'd3, 3'd1, 3'd1, 3'd1, 3'd1, 3'd4, 3'd4,
            3'd4, 3'd4, 3'd6, 3'd6, 3'd7, 3'd7, 3'd2, 3'd5};
    for (int i = 0; i < 600; i++) begin
      st = map[$urandom % 16];
      cyc(st, 1'($urandom % 2));
      n_chk++;
      if (dut_vec() !== mdl_vec() || (bus.mem_we && bus.mem_re)) begin
        n_fail++; $display("FAIL rand_vec %0d st=%0d: got %h want %h", i, st, dut_vec(),
                           mdl_vec());
      end
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    model_reset();
    test_reset();
    test_record();
    test_play();
    test_fwd_back();
    test_full();
    test_reset_mid_read();
    test_loop();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rec_addr_seq.md
REC_ADDR_SEQ -- requirements
Module: rec_addr_seq

Interface
REQ-001 Parameter ADDR_W, default 16: sample memory address width; DEPTH = 2^ADDR_W words.
REQ-002 clk  input  1  system clock; all flops on posedge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 state  input  3  recorder mode code from the control FSM: 000 init, 001 rec, 010 rec pause, 011 rec finish, 100 play, 101 play pause, 110 fwd x2, 111 back x2.
REQ-005 sample_tick  input  1  one-cycle sample-rate strobe.
REQ-006 mem_addr  output  ADDR_W  sample memory address, registered.
REQ-007 mem_we  output  1  one-cycle write strobe, qualifies mem_addr.
REQ-008 mem_re  output  1  one-cycle read strobe, qualifies mem_addr.
REQ-009 rd_valid  output  1  memory read data valid, exactly 1 cycle after mem_re.
REQ-010 finish  output  1  level; playback reached end/start of recording.
REQ-011 full  output  1  level; recording memory exhausted.
REQ-012 rec_len  output  ADDR_W+1  number of samples recorded (wr_ptr).

Function
REQ-013 Internal wr_ptr (ADDR_W+1 bits) and rd_ptr (ADDR_W+1 bits); state input sampled every cycle, actions use the value present in the tick cycle.
REQ-014 state 000: wr_ptr, rd_ptr, finish, full cleared on next edge; no strobes.
REQ-015 state 001, tick, full=0: mem_addr<=wr_ptr, mem_we=1 for 1 cycle, wr_ptr+=1; when wr_ptr becomes DEPTH, full<=1 and further ticks produce no write.
REQ-016 states 010, 101: pointers, flags hold; ticks ignored.
REQ-017 state 011: rd_ptr<=0, finish<=0 every cycle; wr_ptr, full hold.
REQ-018 state 100, tick, rd_ptr<wr_ptr: mem_addr<=rd_ptr, mem_re=1, rd_ptr+=1; finish<=1 in the same edge rd_ptr reaches wr_ptr.
REQ-019 state 110, tick, rd_ptr<wr_ptr: read at rd_ptr, rd_ptr<=min(rd_ptr+2, wr_ptr); finish<=1 when result equals wr_ptr.
REQ-020 state 111, tick, rd_ptr>0: read at rd_ptr-1, rd_ptr<=max(rd_ptr-2, 0); finish<=1 when result is 0.
REQ-021 States 100/110/111 with wr_ptr=0 (empty) or at limit: finish<=1 on first tick, no mem_re.
REQ-022 mem_we and mem_re never asserted in the same cycle; both 0 outside tick cycles.
REQ-023 finish stays 1 until state 011 or 000 is seen; switching 100->110->111 keeps rd_ptr (no rewind).
REQ-024 Illegal/unknown state: treated as hold, no strobes.

Reset
REQ-025 rst_n=0 asynchronously forces mem_addr=0, mem_we=0, mem_re=0, rd_valid=0, finish=0, full=0, wr_ptr=0, rd_ptr=0, including mid-write or mid-read.
REQ-026 First strobe after rst_n release occurs no earlier than first tick seen at a clk edge with rst_n=1.

Configuration
REQ-027 Macro PLAY_LOOP_EN: defined -> in state 100 reaching wr_ptr wraps rd_ptr to 0 and playback continues, finish not asserted in state 100 (110/111 unchanged); undefined -> REQ-018 behaviour.

Verification
REQ-028 Reset, state=001, 5 ticks -> 5 mem_we pulses, addresses 0..4, rec_len=5, full=0.
REQ-029 rec_len=5, state 011 then 100, 5 ticks -> mem_re at addresses 0..4, rd_valid 1 cycle after each, finish=1 on 5th tick edge.
REQ-030 rec_len=10, play 2 ticks (rd_ptr=2), state 110, ticks -> reads at 2,4,6,8, finish after 4th; then state 111 -> reads at 9,7,5,3,1, finish when rd_ptr=0.
REQ-031 ADDR_W=4, state 001, 20 ticks -> exactly 16 writes (0..15), full=1, rec_len=16.
REQ-032 Drop rst_n mid-playback during a mem_re cycle -> all outputs 0 immediately, rec_len=0.
REQ-033 PLAY_LOOP_EN defined, rec_len=3, state 100, 7 ticks -> read addresses 0,1,2,0,1,2,0, finish stays 0.
